inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: boot fetch address.
REQ-002 clk  input  1  main clock; all state changes on posedge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 if_rst, if_en  input  1 each  IF stage reset and enable from the pipeline controller.
REQ-005 id_rst, id_en  input  1 each  IF/ID register reset and enable from the pipeline controller.
REQ-006 if_valid  output  1  fetch buffer holds a valid instruction.
REQ-007 jump_en  input  1  exception/ERET redirect; exc_target  input  32  its target.
REQ-008 branch_taken  input  1  ID-resolved jump/branch redirect; branch_target  input  32  its target.
REQ-009 imem_req  output  1; imem_addr  output  32; imem_ack  input  1; imem_rdata  input  32  instruction memory handshake.
REQ-010 inst_id, pc_id, pc_next_id  output  32 each  IF/ID register: instruction, its PC, PC+4.
REQ-011 id_valid  output  1  IF/ID register holds a valid instruction.

Function
REQ-012 State: fetch_pc (32b), a one-entry fetch buffer (buf_inst, buf_pc, buf_valid), FSM {IDLE, RUN, DRAIN}, drain address (32b).
REQ-013 if_valid SHALL equal buf_valid.
REQ-014 consume = id_en && !id_rst && buf_valid && no redirect this cycle.
REQ-015 Transfer rule: a request is accepted in any cycle with imem_req && imem_ack; rdata is valid only in that cycle.
REQ-016 IDLE: imem_req=0; next state RUN.
REQ-017 RUN: imem_req = if_en && (!buf_valid || consume); imem_addr = fetch_pc.
REQ-018 RUN accepted request (no redirect): buf <= {imem_rdata, fetch_pc, 1}; fetch_pc <= fetch_pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC).
REQ-019 While imem_req=1 and no ack, imem_req and imem_addr SHALL stay stable on the next cycle.
REQ-020 IF/ID register on id_en && !id_rst: inst_id <= buf_inst, pc_id <= buf_pc, pc_next_id <= buf_pc+4, id_valid <= consume; if buffer empty or redirect, load inst 0 with id_valid 0 (bubble).
REQ-021 id_en=0: IF/ID register holds all values.
REQ-022 consume without same-cycle accepted request clears buf_valid; with one, the buffer is refilled (back-to-back throughput 1 instr/cycle at zero wait).
REQ-023 Redirect: jump_en has priority over branch_taken; target = exc_target or branch_target.
REQ-024 Redirect in RUN: fetch_pc <= target, buf_valid <= 0; IF/ID loads bubble if id_en=1; no request is issued that cycle.
REQ-025 Redirect while an unacked request is outstanding: latch its address into the drain register, go to DRAIN.
REQ-026 DRAIN: imem_req=1 at the drain address; on ack discard imem_rdata, go to RUN; later redirects only update fetch_pc.
REQ-027 Redirect in the same cycle as an ack: discard the data, go directly to RUN.
REQ-028 if_en=0 in RUN: no new request is issued; buffer and fetch_pc hold; DRAIN proceeds regardless.
REQ-029 if_rst: fetch_pc <= RESET_PC, buf_valid <= 0, FSM <= IDLE; an outstanding request is completed via DRAIN first.
REQ-030 id_rst takes priority over id_en: inst_id <= 0, pc_id <= 0, pc_next_id <= 0, id_valid <= 0.

Reset
REQ-031 rst SHALL force fetch_pc=RESET_PC, buf_valid=0, FSM=IDLE, inst_id=pc_id=pc_next_id=0, id_valid=0, imem_req=0. This applies even mid-transfer: the memory model is reset with the block.
REQ-032 First request SHALL appear two cycles after rst deasserts (IDLE, then RUN).

Verification
REQ-033 Zero-wait memory with imem_rdata=addr, id_en=1: pc_id sequence 0,4,8,C on consecutive cycles; id_valid=1 from the third cycle after reset.
REQ-034 Ack delayed 3 cycles: imem_addr is stable for 4 cycles; 3 bubbles (id_valid=0, inst_id=0) reach ID.
REQ-035 branch_taken=1, branch_target=32'h100 while request at 0x10 is pending: the 0x10 data is discarded; next accepted request is at 0x100; 0x10 never reaches ID.
REQ-036 jump_en=1 with exc_target=32'h180 and branch_taken=1 with branch_target=32'h40 in the same cycle: next fetch address is 0x180.
REQ-037 id_en=0 for 5 cycles with buffer full: imem_req=0, IF/ID outputs are unchanged, if_valid=1; on release, the held instruction enters ID with no loss or duplication.
REQ-038 fetch_pc=32'hFFFF_FFFC accepted: the next request is at 32'h0000_0000; id_rst pulse: id_valid=0 and inst_id=0 on the next cycle.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one-entry fetch buffer, imem request/ack handshake,
// redirect handling with drain of an in-flight request, and the IF/ID register.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_rst,
   input  logic        if_en,
   input  logic        id_rst,
   input  logic        id_en,
   output logic        if_valid,
   input  logic        jump_en,
   input  logic [31:0] exc_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_id,
   output logic [31:0] pc_id,
   output logic [31:0] pc_next_id,
   output logic        id_valid
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, buf_inst, buf_pc, drain_addr, target;
   logic        buf_valid, pending, redirect, consume, accept;

   assign redirect = jump_en || branch_taken;
   assign target   = jump_en ? exc_target : branch_target;
   assign consume  = id_en && !id_rst && buf_valid && !redirect;
   assign accept   = imem_req && imem_ack;
   assign if_valid = buf_valid;

   // A RUN request still waiting for its ack (pending) must be held; a fresh
   // one is only raised when the buffer has room this cycle.
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      imem_addr = fetch_pc;
      case (state)
         IDLE: state_nxt = if_rst ? IDLE : RUN;
         RUN: begin
            imem_req = pending ||
                       (if_en && !redirect && !if_rst && (!buf_valid || consume));
            if (pending && !imem_ack && (redirect || if_rst))
               state_nxt = DRAIN;
            else if (if_rst)
               state_nxt = IDLE;
         end
         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = drain_addr;
            if (imem_ack)
               state_nxt = if_rst ? IDLE : RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         buf_inst   <= 32'h0;
         buf_pc     <= 32'h0;
         buf_valid  <= 1'b0;
         pending    <= 1'b0;
         drain_addr <= 32'h0;
      end else begin
         state   <= state_nxt;
         pending <= (state == RUN) && imem_req && !imem_ack && !redirect && !if_rst;
         if (state == RUN && pending && (redirect || if_rst))
            drain_addr <= fetch_pc;
         // Redirects discard any data accepted in the same cycle.
         if (if_rst) begin
            fetch_pc  <= RESET_PC;
            buf_valid <= 1'b0;
         end else if (redirect) begin
            fetch_pc  <= target;
            buf_valid <= 1'b0;
         end else if (state == RUN && accept) begin
            buf_inst  <= imem_rdata;
            buf_pc    <= fetch_pc;
            buf_valid <= 1'b1;
            fetch_pc  <= fetch_pc + 32'd4;
         end else if (consume) begin
            buf_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || id_rst) begin
         inst_id    <= 32'h0;
         pc_id      <= 32'h0;
         pc_next_id <= 32'h0;
         id_valid   <= 1'b0;
      end else if (id_en) begin
         inst_id    <= consume ? buf_inst : 32'h0;
         pc_id      <= buf_pc;
         pc_next_id <= buf_pc + 32'd4;
         id_valid   <= consume;
      end
   end

endmodule
